// File: rtl/temp_codec_pkg.sv
// temp_codec_pkg
//   Shared widths, FSM state codes and small helpers for the temperature
//   code encoder (temperature_to_adc_encoder) and its divider core.
//   No ports; imported by every file of the block.
package temp_codec_pkg;

  localparam int TC_TEMP_W  = 32;  // Celsius words (tempc, tc_base)
  localparam int TC_REF_W   = 8;   // reference voltage word
  localparam int TC_ADC_W   = 16;  // sensor code, also width of tc_ref^2
  localparam int TC_MAG_W   = 15;  // magnitude part of the sensor code
  localparam int TC_NUM_W   = 38;  // diff*64+63
  localparam int TC_FRAC_SH = 6;   // fixed-point shift of the forward path
  localparam int TC_CNT_W   = 6;   // wide enough to count the quotient bits
  localparam int TC_DIV_ITER = TC_NUM_W;

  localparam logic [TC_MAG_W-1:0] TC_MAG_MAX = 15'h7FFF;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Sensor code layout: sign selects subtract in the forward path.
  typedef struct packed {
    logic                sign;
    logic [TC_MAG_W-1:0] mag;
  } tc_code_t;

  // tc_ref^2 always fits 16 bits (255^2 = 65025).
  function automatic logic [TC_ADC_W-1:0] tc_square(input logic [TC_REF_W-1:0] r);
    logic [TC_ADC_W-1:0] r_ext;
    r_ext = {{(TC_ADC_W-TC_REF_W){1'b0}}, r};
    return r_ext * r_ext;
  endfunction

endpackage

// File: rtl/temperature_to_adc_encoder_if.sv
// temperature_to_adc_encoder_if
//   Request/response bundle of the encoder.
//   Request  (master -> slave): in_valid, tempc, tc_base, tc_ref; in_ready back.
//   Response (slave -> master): out_valid, adc_data, sat, err; out_ready back.
//   modport master: the stimulus/consumer side.  modport slave: the encoder.
interface temperature_to_adc_encoder_if;
  import temp_codec_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [TC_TEMP_W-1:0] tempc;
  logic [TC_TEMP_W-1:0] tc_base;
  logic [TC_REF_W-1:0]  tc_ref;
  logic                 out_valid;
  logic                 out_ready;
  logic [TC_ADC_W-1:0]  adc_data;
  logic                 sat;
  logic                 err;

  modport master (
    output in_valid, tempc, tc_base, tc_ref, out_ready,
    input  in_ready, out_valid, adc_data, sat, err
  );

  modport slave (
    input  in_valid, tempc, tc_base, tc_ref, out_ready,
    output in_ready, out_valid, adc_data, sat, err
  );

endinterface

// File: rtl/temp_div_core.sv
// temp_div_core
//   38/16 restoring divider, one quotient bit per clock, MSB first.
//   Only the low 15 quotient bits are kept; any 1 shifted past bit 14 sets a
//   sticky overflow flag.
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset (aborts a running division)
//   load_i      in   start a division with num_i / den_i
//   num_i       in   38-bit numerator
//   den_i       in   16-bit denominator (non-zero)
//   busy_o      out  iterations still pending
//   count_o     out  iterations still pending (count)
//   quot_o      out  current 15-bit quotient register
//   ovf_o       out  sticky quotient overflow
//   quot_nxt_o  out  quotient after the step taken on this edge
//   ovf_nxt_o   out  overflow after the step taken on this edge
module temp_div_core
  import temp_codec_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [TC_NUM_W-1:0] num_i,
  input  logic [TC_ADC_W-1:0] den_i,
  output logic                busy_o,
  output logic [TC_CNT_W-1:0] count_o,
  output logic [TC_MAG_W-1:0] quot_o,
  output logic                ovf_o,
  output logic [TC_MAG_W-1:0] quot_nxt_o,
  output logic                ovf_nxt_o
);

  logic [TC_ADC_W-1:0] rem_q;
  logic [TC_NUM_W-1:0] num_q;
  logic [TC_ADC_W-1:0] den_q;
  logic [TC_MAG_W-1:0] quot_q;
  logic                ovf_q;
  logic [TC_CNT_W-1:0] count_q;
  logic                busy_q;

  // The load edge already performs the first iteration, so a division
  // occupies the load edge plus TC_DIV_ITER-1 further edges.
  logic [TC_ADC_W-1:0] rem_src;
  logic                bit_src;
  logic [TC_ADC_W-1:0] den_src;
  logic [TC_MAG_W-1:0] quot_src;
  logic                ovf_src;

  logic [TC_ADC_W:0]   rem_shift;
  logic [TC_ADC_W:0]   rem_sub;
  logic                q_bit;
  logic [TC_ADC_W-1:0] rem_step;
  logic [TC_MAG_W-1:0] quot_step;
  logic                ovf_step;
  logic                unused_rem_msb;

  always_comb begin
    if (load_i) begin
      rem_src  = '0;
      bit_src  = num_i[TC_NUM_W-1];
      den_src  = den_i;
      quot_src = '0;
      ovf_src  = 1'b0;
    end else begin
      rem_src  = rem_q;
      bit_src  = num_q[TC_NUM_W-1];
      den_src  = den_q;
      quot_src = quot_q;
      ovf_src  = ovf_q;
    end
  end

  assign rem_shift = {rem_src, bit_src};
  assign rem_sub   = rem_shift - {1'b0, den_src};
  assign q_bit     = (rem_shift >= {1'b0, den_src});
  // After a successful subtract the remainder is below den, so 16 bits hold it.
  assign rem_step  = q_bit ? rem_sub[TC_ADC_W-1:0] : rem_shift[TC_ADC_W-1:0];
  assign quot_step = {quot_src[TC_MAG_W-2:0], q_bit};
  assign ovf_step  = ovf_src | quot_src[TC_MAG_W-1];
  assign unused_rem_msb = rem_sub[TC_ADC_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      quot_q  <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (load_i) begin
      rem_q   <= rem_step;
      num_q   <= {num_i[TC_NUM_W-2:0], 1'b0};
      den_q   <= den_i;
      quot_q  <= quot_step;
      ovf_q   <= ovf_step;
      count_q <= TC_CNT_W'(TC_DIV_ITER - 1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      rem_q   <= rem_step;
      num_q   <= {num_q[TC_NUM_W-2:0], 1'b0};
      quot_q  <= quot_step;
      ovf_q   <= ovf_step;
      count_q <= count_q - 1'b1;
      busy_q  <= (count_q != TC_CNT_W'(1));
    end
  end

  assign busy_o     = busy_q;
  assign count_o    = count_q;
  assign quot_o     = quot_q;
  assign ovf_o      = ovf_q;
  assign quot_nxt_o = quot_step;
  assign ovf_nxt_o  = ovf_step;

endmodule

// File: rtl/temperature_to_adc_encoder.sv
// temperature_to_adc_encoder
//   Inverse of the temperature calculation path: finds the largest 15-bit code
//   q with (tc_ref^2 * q) >> 6 <= |tempc - tc_base|, plus a sign bit that
//   selects subtract when tempc < tc_base.
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of temperature_to_adc_encoder_if
//          (in_valid/in_ready/tempc/tc_base/tc_ref request,
//           out_valid/out_ready/adc_data/sat/err response)
// Build option
//   TEMP_ENC_EARLY_SAT_EN: detect a saturating quotient during PREP and skip
//   the divider. Results are identical; only the latency shortens.
module temperature_to_adc_encoder
  import temp_codec_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  temperature_to_adc_encoder_if.slave  bus
);

  logic [1:0]           state_q,     state_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [TC_ADC_W-1:0]  adc_data_q,  adc_data_d;
  logic                 sat_q,       sat_d;
  logic                 err_q,       err_d;
  logic [TC_TEMP_W-1:0] tempc_q,     tempc_d;
  logic [TC_TEMP_W-1:0] base_q,      base_d;
  logic [TC_REF_W-1:0]  ref_q,       ref_d;
  logic                 sign_q,      sign_d;

  // PREP arithmetic on the captured request
  logic                 prep_sign;
  logic [TC_TEMP_W-1:0] prep_diff;
  logic [TC_NUM_W-1:0]  prep_num;
  logic [TC_ADC_W-1:0]  prep_den;

  assign prep_sign = (tempc_q < base_q);
  assign prep_diff = prep_sign ? (base_q - tempc_q) : (tempc_q - base_q);
  // The +63 makes the floor division return the largest code whose forward
  // value does not overshoot the target.
  assign prep_num  = {prep_diff, {TC_FRAC_SH{1'b0}}} + TC_NUM_W'(63);
  assign prep_den  = tc_square(ref_q);

`ifdef TEMP_ENC_EARLY_SAT_EN
  // Quotient >= 2^15 exactly when num >= den * 2^15.
  logic prep_early_sat;
  assign prep_early_sat =
    (prep_num[TC_NUM_W-1:TC_MAG_W] >= {{(TC_NUM_W-TC_MAG_W-TC_ADC_W){1'b0}}, prep_den});
`endif

  logic                div_load;
  logic                div_busy;
  logic [TC_CNT_W-1:0] div_count;
  logic [TC_MAG_W-1:0] div_quot;
  logic                div_ovf;
  logic [TC_MAG_W-1:0] div_quot_nxt;
  logic                div_ovf_nxt;
  logic                div_last;

  temp_div_core u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (div_load),
    .num_i      (prep_num),
    .den_i      (prep_den),
    .busy_o     (div_busy),
    .count_o    (div_count),
    .quot_o     (div_quot),
    .ovf_o      (div_ovf),
    .quot_nxt_o (div_quot_nxt),
    .ovf_nxt_o  (div_ovf_nxt)
  );

  // The final quotient bit is taken on the same edge that enters DONE, so the
  // result is latched from the divider's next-step values.
  assign div_last = div_busy && (div_count == TC_CNT_W'(1));

  logic [TC_MAG_W:0] unused_div_state;
  assign unused_div_state = {div_quot, div_ovf};

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    adc_data_d  = adc_data_q;
    sat_d       = sat_q;
    err_d       = err_q;
    tempc_d     = tempc_q;
    base_d      = base_q;
    ref_d       = ref_q;
    sign_d      = sign_q;
    div_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          tempc_d    = bus.tempc;
          base_d     = bus.tc_base;
          ref_d      = bus.tc_ref;
          in_ready_d = 1'b0;
          state_d    = ST_PREP;
        end
      end

      ST_PREP: begin
        sign_d = prep_sign;
        if (ref_q == '0) begin
          err_d       = 1'b1;
          sat_d       = 1'b0;
          adc_data_d  = {prep_sign, TC_MAG_MAX};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
`ifdef TEMP_ENC_EARLY_SAT_EN
        else if (prep_early_sat) begin
          err_d       = 1'b0;
          sat_d       = 1'b1;
          adc_data_d  = {prep_sign, TC_MAG_MAX};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
`endif
        else begin
          div_load = 1'b1;
          state_d  = ST_DIV;
        end
      end

      ST_DIV: begin
        if (div_last) begin
          err_d       = 1'b0;
          sat_d       = div_ovf_nxt;
          adc_data_d  = {sign_q, (div_ovf_nxt ? TC_MAG_MAX : div_quot_nxt)};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      adc_data_q  <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      tempc_q     <= '0;
      base_q      <= '0;
      ref_q       <= '0;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      adc_data_q  <= adc_data_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
      tempc_q     <= tempc_d;
      base_q      <= base_d;
      ref_q       <= ref_d;
      sign_q      <= sign_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.adc_data  = adc_data_q;
  assign bus.sat       = sat_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_temperature_to_adc_encoder.sv
// tb_temperature_to_adc_encoder
//   Directed cases followed by randomized requests, each compared with a
//   plain-arithmetic reference model and a forward-path round-trip check.
module tb_temperature_to_adc_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  temperature_to_adc_encoder_if bus ();

  temperature_to_adc_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: largest q with floor(ref^2*q/64) <= |tempc-base|, clamped.
  task automatic model(input longint t, input longint b, input longint r,
                       output logic [15:0] adc, output logic s, output logic e,
                       output int lat);
    longint diff, den, q;
    logic   sign;
    sign = (t < b);
    diff = sign ? (b - t) : (t - b);
    e = 1'b0;
    s = 1'b0;
    lat = 39;
    if (r == 0) begin
      e = 1'b1;
      adc = {sign, 15'h7FFF};
      lat = 2;
    end else begin
      den = r * r;
      q = (diff * 64 + 63) / den;
      if (q > 32767) begin
        s = 1'b1;
        adc = {sign, 15'h7FFF};
`ifdef TEMP_ENC_EARLY_SAT_EN
        lat = 2;
`endif
      end else begin
        adc = {sign, q[14:0]};
      end
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    check_val("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic run_txn(input logic [31:0] t, input logic [31:0] b, input logic [7:0] r,
                         input int hold);
    logic [15:0] e_adc;
    logic        e_sat, e_err;
    int          e_lat, lat;
    longint      fwd, ok;
    model(t, b, r, e_adc, e_sat, e_err, e_lat);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.tempc    = t;
    bus.tc_base  = b;
    bus.tc_ref   = r;
    @(posedge clk);
    @(negedge clk);
    // inputs captured on the accept edge; scramble them afterwards
    bus.in_valid = 1'b0;
    bus.tempc    = $urandom;
    bus.tc_base  = $urandom;
    bus.tc_ref   = 8'($urandom);
    check_val("in_ready_busy", {63'd0, bus.in_ready}, 64'd0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check_val("latency", 64'(lat), 64'(e_lat));
    check_val("adc_data", {48'd0, bus.adc_data}, {48'd0, e_adc});
    check_val("sat", {63'd0, bus.sat}, {63'd0, e_sat});
    check_val("err", {63'd0, bus.err}, {63'd0, e_err});
    check_val("in_ready_done", {63'd0, bus.in_ready}, 64'd0);
    if (!e_sat && !e_err) begin
      fwd = (longint'(r) * longint'(r) * longint'(bus.adc_data[14:0])) >> 6;
      if (bus.adc_data[15]) ok = (longint'(b) - fwd >= longint'(t)) ? 1 : 0;
      else                  ok = (longint'(b) + fwd <= longint'(t)) ? 1 : 0;
      check_val("forward_bound", 64'(ok), 64'd1);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check_val("hold_adc", {48'd0, bus.adc_data}, {48'd0, e_adc});
      check_val("hold_flags", {62'd0, bus.sat, bus.err}, {62'd0, e_sat, e_err});
      check_val("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val("out_valid_drop", {63'd0, bus.out_valid}, 64'd0);
    $display("txn tempc=%0d base=%0d ref=%0d adc=%h sat=%b err=%b lat=%0d",
             t, b, r, e_adc, e_sat, e_err, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rt, rb, dl;
    logic [7:0]  rr;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.tempc     = '0;
    bus.tc_base   = '0;
    bus.tc_ref    = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check_val("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_val("rst_adc", {48'd0, bus.adc_data}, 64'd0);
    check_val("rst_flags", {62'd0, bus.sat, bus.err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_release_ready", {63'd0, bus.in_ready}, 64'd1);

    // directed cases
    run_txn(32'd100, 32'd0, 8'd8, 0);
    run_txn(32'd900, 32'd1000, 8'd8, 1);
    run_txn(32'd15, 32'd5, 8'd16, 0);
    run_txn(32'd1000, 32'd0, 8'd1, 0);
    run_txn(32'd3, 32'd7, 8'd0, 0);
    run_txn(32'd42, 32'd42, 8'd1, 0);
    run_txn(32'd0, 32'hFFFF_FFFF, 8'd255, 0);
    run_txn(32'd5000, 32'd2000, 8'd200, 5);

    // abort mid-division
    wait_ready();
    bus.in_valid = 1'b1;
    bus.tempc    = 32'd777;
    bus.tc_base  = 32'd11;
    bus.tc_ref   = 8'd9;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check_val("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    check_val("abort_adc", {48'd0, bus.adc_data}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_release_ready", {63'd0, bus.in_ready}, 64'd1);
    run_txn(32'd777, 32'd11, 8'd9, 0);

    // randomized requests
    for (int n = 0; n < 40; n++) begin
      rr = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) begin
        rt = $urandom;
        rb = $urandom;
      end else begin
        rb = $urandom_range(0, 32'h7FFF_FFFF);
        dl = $urandom_range(0, 60000);
        if ($urandom_range(0, 1) == 1) rt = rb + dl;
        else                           rt = (rb > dl) ? rb - dl : 32'd0;
      end
      run_txn(rt, rb, rr, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
